// File: rtl/snes_pad_responder_if.sv
// Host-side signal bundle for the SNES pad responder: latch/pulse/buttons in,
// serial reply and status out.
interface snes_pad_responder_if;
  logic        LATCH;
  logic        PULSE;
  logic [11:0] BUTTONS;
  logic        DATA;
  logic        BUSY;
  logic        FRAME_DONE;
  logic [7:0]  POLL_COUNT;

  modport master (
    output LATCH, PULSE, BUTTONS,
    input  DATA, BUSY, FRAME_DONE, POLL_COUNT
  );

  modport slave (
    input  LATCH, PULSE, BUTTONS,
    output DATA, BUSY, FRAME_DONE, POLL_COUNT
  );
endinterface

// File: rtl/snes_pad_responder.sv
// SNES controller emulator: answers host LATCH/PULSE polls with a 16-bit serial frame.
// Optional input glitch filter enabled by defining SNES_RESP_GLITCH_FILTER_EN.
module snes_pad_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                 CLOCK,
  input logic                 CLR,
  snes_pad_responder_if.slave pad
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  logic [1:0] latch_sync, pulse_sync;
  logic       latch_cur, pulse_cur;
  logic       latch_prev_q, pulse_prev_q;
  logic       latch_rise, latch_fall, pulse_rise;

  always_ff @(posedge CLOCK or posedge CLR) begin
    if (CLR) begin
      latch_sync <= 2'b00;
      pulse_sync <= 2'b11;
    end else begin
      latch_sync <= {latch_sync[0], pad.LATCH};
      pulse_sync <= {pulse_sync[0], pad.PULSE};
    end
  end

`ifdef SNES_RESP_GLITCH_FILTER_EN
  // Two-deep history of each synchronized input; the filtered value (held in
  // the edge detector's previous-value flop) moves only on three equal samples.
  logic [1:0] latch_hist, pulse_hist;

  always_ff @(posedge CLOCK or posedge CLR) begin
    if (CLR) begin
      latch_hist <= 2'b00;
      pulse_hist <= 2'b11;
    end else begin
      latch_hist <= {latch_hist[0], latch_sync[1]};
      pulse_hist <= {pulse_hist[0], pulse_sync[1]};
    end
  end

  assign latch_cur = (latch_sync[1] == latch_hist[0] && latch_sync[1] == latch_hist[1]) ?
                     latch_sync[1] : latch_prev_q;
  assign pulse_cur = (pulse_sync[1] == pulse_hist[0] && pulse_sync[1] == pulse_hist[1]) ?
                     pulse_sync[1] : pulse_prev_q;
`else
  assign latch_cur = latch_sync[1];
  assign pulse_cur = pulse_sync[1];
`endif

  always_ff @(posedge CLOCK or posedge CLR) begin
    if (CLR) begin
      latch_prev_q <= 1'b0;
      pulse_prev_q <= 1'b1;
    end else begin
      latch_prev_q <= latch_cur;
      pulse_prev_q <= pulse_cur;
    end
  end

  assign latch_rise = latch_cur & ~latch_prev_q;
  assign latch_fall = ~latch_cur & latch_prev_q;
  assign pulse_rise = pulse_cur & ~pulse_prev_q;

  state_e            state_q, state_d;
  logic [15:0]       sreg_q, sreg_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        poll_q, poll_d;
  logic [15:0]       load_word;

  // Top nibble is the released ID field; buttons are sent active-low.
  assign load_word = {4'b1111, ~pad.BUTTONS};

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_d        = tmo_q;
    frame_done_d = 1'b0;
    poll_d       = poll_q;

    if (latch_rise) begin
      // Re-latch wins over everything, including a same-cycle pulse edge.
      state_d   = StLoad;
      sreg_d    = load_word;
      bit_cnt_d = 5'd0;
      tmo_d     = '0;
    end else begin
      case (state_q)
        StIdle: ;
        StLoad: begin
          sreg_d = load_word;
          if (latch_fall) begin
            state_d   = StShift;
            bit_cnt_d = 5'd0;
            tmo_d     = '0;
          end
        end
        StShift: begin
          if (pulse_rise) begin
            sreg_d    = {1'b0, sreg_q[15:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
            tmo_d     = '0;
            if (bit_cnt_q == 5'd15) begin
              state_d      = StDone;
              frame_done_d = 1'b1;
              poll_d       = poll_q + 8'd1;
            end
          end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
            sreg_d  = '1;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
        StDone: sreg_d = '0;
        default: begin
          state_d = StIdle;
          sreg_d  = '1;
        end
      endcase
    end

    busy_d = (state_d == StLoad) || (state_d == StShift);
  end

  always_ff @(posedge CLOCK or posedge CLR) begin
    if (CLR) begin
      state_q      <= StIdle;
      sreg_q       <= 16'hFFFF;
      bit_cnt_q    <= 5'd0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      poll_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      poll_q       <= poll_d;
    end
  end

  assign pad.DATA       = sreg_q[0];
  assign pad.BUSY       = busy_q;
  assign pad.FRAME_DONE = frame_done_q;
  assign pad.POLL_COUNT = poll_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Self-checking bench for snes_pad_responder: table-driven polls, corner-case
// sequences and randomized frames checked against a bit-level reply model.
module tb_snes_pad_responder;

  localparam int unsigned Tmo = 100;
`ifdef SNES_RESP_GLITCH_FILTER_EN
  localparam int Lat = 5;
`else
  localparam int Lat = 3;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  snes_pad_responder_if pad ();

  snes_pad_responder #(.TIMEOUT_CYCLES(Tmo)) dut (
    .CLOCK (clk),
    .CLR   (clr),
    .pad   (pad)
  );

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  logic [7:0] exp_poll;

  always @(negedge clk) if (pad.FRAME_DONE === 1'b1) fd_count++;

  typedef struct {
    logic [11:0] buttons;
    logic [15:0] word;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reply the host should sample: 12 active-low buttons then four released ID bits.
  function automatic logic [15:0] model_word(input logic [11:0] b);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = (i < 12) ? !b[i] : 1'b1;
    return w;
  endfunction

  task automatic start_shift(input logic [11:0] b);
    pad.BUTTONS = b;
    pad.LATCH   = 1'b1;
    tick(6);
    chk("busy_load", {15'd0, pad.BUSY}, 16'd1);
    pad.LATCH = 1'b0;
    tick(4);
    pad.BUTTONS = 12'($urandom);
    tick(2);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      pad.PULSE = 1'b0;
      tick(4);
      pad.PULSE = 1'b1;
      tick(4);
    end
  endtask

  task automatic run_frame(input logic [11:0] b, input logic [15:0] w, input string nm);
    int fd0;
    start_shift(b);
    fd0 = fd_count;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_bit%0d", nm, i), {15'd0, pad.DATA}, {15'd0, w[i]});
      chk($sformatf("%s_busy%0d", nm, i), {15'd0, pad.BUSY}, 16'd1);
      pulses(1);
    end
    tick(2);
    exp_poll = exp_poll + 8'd1;
    chk({nm, "_data_done"}, {15'd0, pad.DATA}, 16'd0);
    chk({nm, "_busy_done"}, {15'd0, pad.BUSY}, 16'd0);
    chk({nm, "_frame_done"}, 16'(fd_count - fd0), 16'd1);
    chk({nm, "_poll"}, {8'd0, pad.POLL_COUNT}, {8'd0, exp_poll});
  endtask

  initial begin
    int fd0;
    logic [11:0] b;

    tbl[0] = '{12'h001, 16'hFFFE};
    tbl[1] = '{12'hA5C, 16'hF5A3};
    tbl[2] = '{12'hFFF, 16'hF000};
    tbl[3] = '{12'h000, 16'hFFFF};

    clr = 1'b1;
    pad.LATCH = 1'b0;
    pad.PULSE = 1'b1;
    pad.BUTTONS = 12'h000;
    exp_poll = 8'd0;
    tick(3);
    chk("rst_data", {15'd0, pad.DATA}, 16'd1);
    chk("rst_busy", {15'd0, pad.BUSY}, 16'd0);
    chk("rst_fd", {15'd0, pad.FRAME_DONE}, 16'd0);
    chk("rst_poll", {8'd0, pad.POLL_COUNT}, 16'd0);
    clr = 1'b0;
    tick(2);

    // Pulses with no latch must not start shifting.
    pulses(3);
    chk("idle_pulse_data", {15'd0, pad.DATA}, 16'd1);
    chk("idle_pulse_busy", {15'd0, pad.BUSY}, 16'd0);

    // Latch edge latency.
    pad.BUTTONS = 12'h001;
    pad.LATCH = 1'b1;
    tick(Lat - 1);
    chk("lat_early_busy", {15'd0, pad.BUSY}, 16'd0);
    tick(1);
    chk("lat_busy", {15'd0, pad.BUSY}, 16'd1);
    chk("lat_data", {15'd0, pad.DATA}, 16'd0);
    pad.LATCH = 1'b0;
    tick(8);

    for (int i = 0; i < 4; i++) run_frame(tbl[i].buttons, tbl[i].word, $sformatf("tbl%0d", i));

    // Extra pulses in DONE keep DATA low and leave the count alone.
    fd0 = fd_count;
    pulses(2);
    chk("done_extra_data", {15'd0, pad.DATA}, 16'd0);
    chk("done_extra_poll", {8'd0, pad.POLL_COUNT}, {8'd0, exp_poll});
    chk("done_extra_fd", 16'(fd_count - fd0), 16'd0);

    // Re-latch after 7 pulses: aborted frame does not count.
    start_shift(12'h3C3);
    pulses(7);
    run_frame(12'hFFF, 16'hF000, "relatch");

    // Timeout after 3 pulses and silence.
    fd0 = fd_count;
    start_shift(12'h5A5);
    pulses(3);
    tick(95);
    chk("tmo_busy_before", {15'd0, pad.BUSY}, 16'd1);
    tick(8);
    chk("tmo_busy_after", {15'd0, pad.BUSY}, 16'd0);
    chk("tmo_data", {15'd0, pad.DATA}, 16'd1);
    chk("tmo_fd", 16'(fd_count - fd0), 16'd0);
    chk("tmo_poll", {8'd0, pad.POLL_COUNT}, {8'd0, exp_poll});

    // Short glitches on PULSE during SHIFT.
    start_shift(12'h001);
`ifdef SNES_RESP_GLITCH_FILTER_EN
    pad.PULSE = 1'b0;
    tick(1);
    pad.PULSE = 1'b1;
    tick(8);
    chk("glitch_filtered", {15'd0, pad.DATA}, 16'd0);
`else
    pad.PULSE = 1'b0;
    tick(2);
    pad.PULSE = 1'b1;
    tick(4);
    chk("glitch_accepted", {15'd0, pad.DATA}, 16'd1);
`endif

    // CLR during the fifth frame.
    for (int i = 0; i < 4; i++) begin
      b = 12'($urandom);
      run_frame(b, model_word(b), $sformatf("pre%0d", i));
    end
    start_shift(12'h001);
    pulses(3);
    #2 clr = 1'b1;
    #1;
    chk("clr_data", {15'd0, pad.DATA}, 16'd1);
    chk("clr_busy", {15'd0, pad.BUSY}, 16'd0);
    chk("clr_poll", {8'd0, pad.POLL_COUNT}, 16'd0);
    exp_poll = 8'd0;
    tick(2);
    clr = 1'b0;
    tick(2);
    pulses(3);
    chk("clr_after_data", {15'd0, pad.DATA}, 16'd1);
    chk("clr_after_busy", {15'd0, pad.BUSY}, 16'd0);

    // 256 random frames wrap the count back to zero.
    for (int i = 0; i < 256; i++) begin
      b = 12'($urandom);
      run_frame(b, model_word(b), $sformatf("rnd%0d", i));
    end
    chk("poll_wrap", {8'd0, pad.POLL_COUNT}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
